// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared register-file bus types and constants used by the write-back arbiter.
package regfile_wb_arbiter_pkg;
    localparam int REG_DATA_W = 32;
    localparam int REG_ADDR_W = 5;

    typedef logic [REG_DATA_W-1:0] RegBus;
    typedef logic [REG_ADDR_W-1:0] RegAddrBus;

    localparam RegBus     ZeroWord     = '0;
    localparam RegAddrBus NOPRegAddr   = '0;
    localparam logic      WriteEnable  = 1'b1;
    localparam logic      WriteDisable = 1'b0;
endpackage

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// Long-latency result buffer: circular storage with per-entry valid/live bits,
// kill-by-address for WAW squashing, and two address-match query ports.
module wb_fifo #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              kill,
    input  logic [ADDR_W-1:0] kill_addr,
    output logic              full,
    output logic              empty,
    output logic              head_live,
    output logic [ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0] head_data,
    input  logic [ADDR_W-1:0] q1_addr,
    input  logic [ADDR_W-1:0] q2_addr,
    output logic              q1_hit,
    output logic              q2_hit
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DEPTH-1:0][ADDR_W-1:0] ent_addr;
    logic [DEPTH-1:0][DATA_W-1:0] ent_data;
    logic [DEPTH-1:0]             ent_vld;
    logic [DEPTH-1:0]             ent_live;
    logic [DEPTH-1:0]             q1_match;
    logic [DEPTH-1:0]             q2_match;
    logic [PTR_W-1:0]             rd_ptr;
    logic [PTR_W-1:0]             wr_ptr;
    logic [PTR_W:0]               count;

    assign full      = (count == (PTR_W+1)'(DEPTH));
    assign empty     = (count == '0);
    assign head_live = ent_live[rd_ptr];
    assign head_addr = ent_addr[rd_ptr];
    assign head_data = ent_data[rd_ptr];

    // Callers keep address 0 out of the FIFO, so no zero filter is needed here.
    for (genvar i = 0; i < DEPTH; i++) begin : g_match
        assign q1_match[i] = ent_vld[i] && ent_live[i] && (ent_addr[i] == q1_addr);
        assign q2_match[i] = ent_vld[i] && ent_live[i] && (ent_addr[i] == q2_addr);
    end
    assign q1_hit = |q1_match;
    assign q2_hit = |q2_match;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ent_addr <= '0;
            ent_data <= '0;
            ent_vld  <= '0;
            ent_live <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill && ent_vld[i] && (ent_addr[i] == kill_addr))
                    ent_live[i] <= 1'b0;
            end
            if (pop) begin
                ent_vld[rd_ptr] <= 1'b0;
                rd_ptr          <= rd_ptr + PTR_W'(1);
            end
            // The write slot is never valid when not full, so this cannot collide with the kill.
            if (push) begin
                ent_vld[wr_ptr]  <= 1'b1;
                ent_live[wr_ptr] <= 1'b1;
                ent_addr[wr_ptr] <= push_addr;
                ent_data[wr_ptr] <= push_data;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: MEM/WB writes take priority over buffered
// long-latency results; the output port is registered.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipe_we,
    input  logic [ADDR_W-1:0] pipe_waddr,
    input  logic [DATA_W-1:0] pipe_wdata,
    input  logic              lu_valid,
    output logic              lu_ready,
    input  logic [ADDR_W-1:0] lu_waddr,
    input  logic [DATA_W-1:0] lu_wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic              busy1,
    output logic              busy2,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata
);
    logic              pipe_sel;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic              head_live;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic              q1_hit;
    logic              q2_hit;

    assign pipe_sel = pipe_we && (pipe_waddr != ADDR_W'(NOPRegAddr));
    assign pop      = !pipe_sel && !empty;
    // Held low through reset so producers never handshake into a FIFO being cleared.
    assign lu_ready = rst && !full;
    assign push     = lu_valid && lu_ready && (lu_waddr != ADDR_W'(NOPRegAddr));
    assign busy1    = (raddr1 != ADDR_W'(NOPRegAddr)) && q1_hit;
    assign busy2    = (raddr2 != ADDR_W'(NOPRegAddr)) && q2_hit;

    wb_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_addr (lu_waddr),
        .push_data (lu_wdata),
        .pop       (pop),
        .kill      (pipe_sel),
        .kill_addr (pipe_waddr),
        .full      (full),
        .empty     (empty),
        .head_live (head_live),
        .head_addr (head_addr),
        .head_data (head_data),
        .q1_addr   (raddr1),
        .q2_addr   (raddr2),
        .q1_hit    (q1_hit),
        .q2_hit    (q2_hit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we    <= WriteDisable;
            waddr <= ADDR_W'(NOPRegAddr);
            wdata <= DATA_W'(ZeroWord);
        end else if (pipe_sel) begin
            we    <= WriteEnable;
            waddr <= pipe_waddr;
            wdata <= pipe_wdata;
        end else if (pop && head_live) begin
            we    <= WriteEnable;
            waddr <= head_addr;
            wdata <= head_data;
        end else begin
            // Idle cycles and discarded dead entries leave address/data untouched.
            we    <= WriteDisable;
        end
    end
endmodule
